// File: rtl/cordic_pkg.sv
// cordic_pkg -- shared constants and types for the CORDIC sine/cosine block.
//   WIDTH      : datapath width (32)
//   ITER       : number of micro-rotations (30)
//   K_INIT     : starting x magnitude, the CORDIC gain reciprocal in Q2.30,
//                so the result comes out unity-scaled with no post-multiply
//   ATAN_TABLE : atan(2^-i) as a binary angle (2^32 = one full turn)
//   state_t    : controller states
package cordic_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 30;

    localparam logic signed [WIDTH-1:0] K_INIT = 32'sh26DD_3B6A;

    localparam logic [WIDTH-1:0] ATAN_TABLE [0:ITER-1] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom -- combinational lookup of the per-iteration rotation angle.
//   idx      : iteration index 0..29 (values >= 30 return 0)
//   atan_val : atan(2^-idx) as a 32-bit binary angle
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [4:0]       idx,
    output logic [WIDTH-1:0] atan_val
);

    always_comb begin
        atan_val = '0;
        if (int'(idx) < ITER) begin
            atan_val = ATAN_TABLE[idx];
        end
    end

endmodule

// File: rtl/cordic.sv
// cordic -- iterative rotation-mode CORDIC producing cos/sin of a binary angle.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   start : request, sampled only while idle
//   angle : unsigned binary angle (2^32 = full turn), sampled with start
//   done  : level, high while a fresh result is presented
//   out_x : cos(angle), signed Q2.30
//   out_y : sin(angle), signed Q2.30
// One micro-rotation per cycle; result appears 30 cycles after the sampling edge.
module cordic
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    output logic             done,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t state_reg, state_next;

    logic signed [WIDTH-1:0] x_reg, y_reg, z_reg;
    logic        [4:0]       iter_reg;
    logic                    done_reg;
    logic        [WIDTH-1:0] out_x_reg, out_y_reg;

    logic        [WIDTH-1:0] atan_val;
    logic signed [WIDTH-1:0] x_shift, y_shift;
    logic signed [WIDTH-1:0] x_next, y_next, z_next;
    logic                    flip_half;
    logic signed [WIDTH-1:0] x_load, z_load;

    cordic_atan_rom u_atan_rom (
        .idx      (iter_reg),
        .atan_val (atan_val)
    );

    // Quadrants 01/10 lie outside CORDIC's convergence range (~+/-99.9 deg):
    // start from -K and rotate by angle-180 deg instead.
    assign flip_half = angle[WIDTH-1] ^ angle[WIDTH-2];
    assign x_load    = flip_half ? -K_INIT : K_INIT;
    assign z_load    = flip_half ? $signed(angle - 32'h8000_0000) : $signed(angle);

    // One micro-rotation; direction follows the sign of the residual angle.
    always_comb begin
        x_shift = x_reg >>> iter_reg;
        y_shift = y_reg >>> iter_reg;
        if (!z_reg[WIDTH-1]) begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - $signed(atan_val);
        end else begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + $signed(atan_val);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)                  state_next = ST_CALC;
            ST_CALC: if (iter_reg == LAST_ITER)  state_next = ST_DONE;
            ST_DONE: if (!start)                 state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            done_reg  <= 1'b0;
            out_x_reg <= '0;
            out_y_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x_reg    <= x_load;
                        y_reg    <= '0;
                        z_reg    <= z_load;
                        iter_reg <= '0;
                    end
                end
                ST_CALC: begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + 5'd1;
                    // Outputs only ever take a completed result.
                    if (iter_reg == LAST_ITER) begin
                        out_x_reg <= x_next;
                        out_y_reg <= y_next;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done_reg <= 1'b0;
                    end
                end
                default: begin
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign done  = done_reg;
    assign out_x = out_x_reg;
    assign out_y = out_y_reg;

endmodule

// File: tb/tb_cordic.sv
// tb_cordic -- randomized self-checking bench for cordic.
// A behavioural model (cycle countdown + real-valued cos/sin) predicts done
// and the outputs; a negedge compare process checks them every cycle.
module tb_cordic;

    localparam real TWO_PI = 6.283185307179586;
    localparam real TURN   = 4294967296.0;
    localparam real ONE    = 1073741824.0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] angle;
    logic        done;
    logic [31:0] out_x;
    logic [31:0] out_y;

    int total = 0;
    int bad   = 0;

    cordic dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .angle (angle),
        .done  (done),
        .out_x (out_x),
        .out_y (out_y)
    );

    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check_tol(input string nm, input logic [31:0] act, input real expv);
        real d;
        d = real'($signed(act)) - expv;
        total++;
        if (d > 64.0 || d < -64.0) begin
            bad++;
            $display("FAIL %s: got %0d want %0.1f +/-64", nm, $signed(act), expv);
        end
    endtask

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          m_have  = 0;
    bit          m_wrote = 1;
    int          m_cnt   = 0;
    logic [31:0] m_angle = '0;
    real         m_x     = 0.0;
    real         m_y     = 0.0;

    always @(posedge clk or negedge reset) begin
        m_wrote = 0;
        if (!reset) begin
            m_busy  = 0;
            m_done  = 0;
            m_have  = 0;
            m_cnt   = 0;
            m_x     = 0.0;
            m_y     = 0.0;
            m_wrote = 1;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy  = 0;
                m_done  = 1;
                m_have  = 1;
                m_wrote = 1;
                m_x = $cos(TWO_PI * real'(longint'(m_angle)) / TURN) * ONE;
                m_y = $sin(TWO_PI * real'(longint'(m_angle)) / TURN) * ONE;
            end
        end else if (m_done) begin
            if (!start) m_done = 0;
        end else if (start) begin
            m_busy  = 1;
            m_cnt   = 30;
            m_angle = angle;
        end
    end

    // ---------------- compare process ----------------
    bit          chk_en  = 0;
    bit          prev_ok = 0;
    logic [31:0] prev_x, prev_y;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("done", {31'b0, done}, {31'b0, m_done});
            if (!m_have) begin
                check_eq("out_x_zero", out_x, 32'h0);
                check_eq("out_y_zero", out_y, 32'h0);
            end else begin
                check_tol("out_x", out_x, m_x);
                check_tol("out_y", out_y, m_y);
            end
            if (prev_ok && !m_wrote) begin
                check_eq("hold_x", out_x, prev_x);
                check_eq("hold_y", out_y, prev_y);
            end
            prev_x  = out_x;
            prev_y  = out_y;
            prev_ok = 1;
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request, scramble angle during CALC, hold start until done
    // plus extra cycles, then release start.
    task automatic run_one(input logic [31:0] a, input int extra_hold);
        int lat;
        @(negedge clk);
        start = 1'b1;
        angle = a;
        @(negedge clk);
        angle = $urandom();
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            angle = $urandom();
        end
        check_eq("latency", 32'(lat), 32'd30);
        repeat (extra_hold) @(negedge clk);
        check_eq("done_held", {31'b0, done}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check_eq("done_clear", {31'b0, done}, 32'd0);
    endtask

    logic [31:0] corner_tbl [10] = '{
        32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h2000_0000,
        32'hC000_0000, 32'h3FFF_FFFF, 32'h7FFF_FFFF, 32'hBFFF_FFFF,
        32'hFFFF_FFFF, 32'h6000_0000
    };

    initial begin
        reset = 1'b0;
        start = 1'b0;
        angle = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_x", out_x, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Hand-computed expectations pin the model.
        run_one(32'h0000_0000, 0);
        check_tol("cos0", out_x, 1073741824.0);
        check_tol("sin0", out_y, 0.0);
        run_one(32'h4000_0000, 0);
        check_tol("cos90", out_x, 0.0);
        check_tol("sin90", out_y, 1073741824.0);
        run_one(32'h8000_0000, 0);
        check_tol("cos180", out_x, -1073741824.0);
        check_tol("sin180", out_y, 0.0);
        run_one(32'h2000_0000, 0);
        check_tol("cos45", out_x, 759250125.0);
        check_tol("sin45", out_y, 759250125.0);
        run_one(32'hC000_0000, 10);
        check_tol("sin270", out_y, -1073741824.0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a calculation.
        start = 1'b1;
        angle = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_done", {31'b0, done}, 32'd0);
        check_eq("arst_x", out_x, 32'h0);
        check_eq("arst_y", out_y, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_one(32'h4000_0000, 0);
        check_tol("post_rst_sin", out_y, 1073741824.0);

        foreach (corner_tbl[i]) run_one(corner_tbl[i], 0);
        for (int n = 0; n < 1000; n++) run_one($urandom(), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
